// File: rtl/lt24_hires_keys_pio.sv
// Avalon-MM pushbutton/switch input port: per-bit synchronizer and debouncer,
// sticky edge-capture register with write-1-to-clear, and a maskable level irq.
module lt24_hires_keys_pio #(
    parameter int   WIDTH           = 4,
    parameter int   DEBOUNCE_CYCLES = 50000,
    parameter int   EDGE_TYPE       = 1,
    parameter logic IDLE_LEVEL      = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [WIDTH-1:0] IDLE     = {WIDTH{IDLE_LEVEL}};

    // Bus handshake: a write is accepted on any clock where chipselect is high
    // and write_n is low; there is no wait-state, and readdata is registered
    // from the address presented at the previous edge (fixed latency of one).
    logic             wr_en;
    logic [WIDTH-1:0] clr;
    logic [WIDTH-1:0] edge_det;
    logic             unused_wdata;

    logic [WIDTH-1:0] sync1_d, sync1_q, sync2_d, sync2_q;
    logic [WIDTH-1:0] stable_d, stable_q, stable_dly_d, stable_dly_q;
    logic [WIDTH-1:0] ecap_d, ecap_q, mask_d, mask_q;
    logic [CNT_W-1:0] cnt_d [WIDTH];
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [31:0]      readdata_d, readdata_q;

    assign unused_wdata = ^writedata;

    always_comb begin
        sync1_d      = in_port;
        sync2_d      = sync1_q;
        stable_dly_d = stable_q;
        stable_d     = stable_q;
        cnt_d        = cnt_q;
        // Any return to the stable level restarts the count from zero.
        for (int i = 0; i < WIDTH; i++) begin
            if (sync2_q[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                stable_d[i] = sync2_q[i];
                cnt_d[i]    = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end

        case (EDGE_TYPE)
            0:       edge_det = stable_q & ~stable_dly_q;
            1:       edge_det = ~stable_q & stable_dly_q;
            default: edge_det = stable_q ^ stable_dly_q;
        endcase

        wr_en  = chipselect & ~write_n;
        clr    = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
        // A new edge wins over a simultaneous clear of the same bit.
        ecap_d = edge_det | (ecap_q & ~clr);
        mask_d = (wr_en && address == 2'd2) ? writedata[WIDTH-1:0] : mask_q;

        readdata_d = '0;
        case (address)
            2'd0:    readdata_d[WIDTH-1:0] = stable_q;
            2'd2:    readdata_d[WIDTH-1:0] = mask_q;
            2'd3:    readdata_d[WIDTH-1:0] = ecap_q;
            default: readdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q      <= IDLE;
            sync2_q      <= IDLE;
            stable_q     <= IDLE;
            stable_dly_q <= IDLE;
            ecap_q       <= '0;
            mask_q       <= '0;
            readdata_q   <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            stable_q     <= stable_d;
            stable_dly_q <= stable_dly_d;
            ecap_q       <= ecap_d;
            mask_q       <= mask_d;
            readdata_q   <= readdata_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign readdata = readdata_q;
    assign irq      = |(ecap_q & mask_q);

endmodule

// File: tb/tb_lt24_hires_keys_pio.sv
// Directed bench for lt24_hires_keys_pio with WIDTH=4, DEBOUNCE_CYCLES=4,
// falling-edge capture; inputs driven and outputs sampled on the falling clock edge.
module tb_lt24_hires_keys_pio;

    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [3:0]  in_port;
    logic        irq;

    int checks = 0;
    int errors = 0;
    logic [31:0] rd;

    lt24_hires_keys_pio #(
        .WIDTH(4),
        .DEBOUNCE_CYCLES(4),
        .EDGE_TYPE(1),
        .IDLE_LEVEL(1'b1)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .address(address),
        .chipselect(chipselect),
        .write_n(write_n),
        .writedata(writedata),
        .readdata(readdata),
        .in_port(in_port),
        .irq(irq)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish, expected finish before 100000");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // driver tasks: each consumes one clock, ending at the falling edge after it
    task automatic bus_rd(input logic [1:0] a, output logic [31:0] d);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        @(negedge clk);
        d = readdata;
    endtask

    task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        write_n    = 1'b1;
        chipselect = 1'b0;
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        reset_n    = 1'b0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in_port    = 4'hF;
        wait_clks(3);
        chk("reset_readdata", readdata, 32'h0);
        chk("reset_irq", {31'b0, irq}, 32'h0);
        reset_n = 1'b1;

        bus_rd(2'd0, rd); chk("rst_data", rd, 32'hF);
        bus_rd(2'd1, rd); chk("rst_rsvd", rd, 32'h0);
        bus_rd(2'd2, rd); chk("rst_mask", rd, 32'h0);
        bus_rd(2'd3, rd); chk("rst_ecap", rd, 32'h0);
        chk("rst_irq_after", {31'b0, irq}, 32'h0);

        // falling edge on bit 0 with bit 0 unmasked; capture lands at edge k+6
        bus_wr(2'd2, 32'h1);
        bus_wr(2'd1, 32'hFFFF_FFFF);
        bus_rd(2'd1, rd); chk("rsvd_write_ignored", rd, 32'h0);
        address = 2'd0;
        in_port = 4'hE;
        wait_clks(6);
        chk("data_before_k6", readdata, 32'hF);
        chk("irq_before_k6", {31'b0, irq}, 32'h0);
        wait_clks(1);
        chk("data_from_k6", readdata, 32'hE);
        chk("irq_after_k6", {31'b0, irq}, 32'h1);
        bus_rd(2'd3, rd); chk("ecap_bit0", rd, 32'h1);

        // bit 1 low for 3 clocks: filtered out
        in_port = 4'hC;
        wait_clks(3);
        in_port = 4'hE;
        wait_clks(10);
        bus_rd(2'd0, rd); chk("glitch3_data", rd, 32'hE);
        bus_rd(2'd3, rd); chk("glitch3_ecap", rd, 32'h1);

        // bit 1 low for 4 clocks: just long enough to be captured
        in_port = 4'hC;
        wait_clks(4);
        in_port = 4'hE;
        wait_clks(15);
        bus_rd(2'd3, rd); chk("pulse4_ecap", rd, 32'h3);
        bus_rd(2'd0, rd); chk("pulse4_data_settled", rd, 32'hE);

        // masking and write-1-to-clear
        bus_wr(2'd3, 32'h2);
        chk("irq_mask1_ecap1", {31'b0, irq}, 32'h1);
        bus_rd(2'd3, rd); chk("w1c_bit1", rd, 32'h1);
        bus_wr(2'd2, 32'h0);
        chk("irq_masked", {31'b0, irq}, 32'h0);
        bus_wr(2'd2, 32'h1);
        chk("irq_unmasked", {31'b0, irq}, 32'h1);
        bus_rd(2'd2, rd); chk("mask_readback", rd, 32'h1);
        bus_wr(2'd3, 32'h1);
        chk("irq_after_clear", {31'b0, irq}, 32'h0);
        bus_rd(2'd3, rd); chk("ecap_cleared", rd, 32'h0);

        // bit 2 falls so its capture edge coincides with a clear of bit 2
        bus_wr(2'd2, 32'h4);
        in_port = 4'hA;
        wait_clks(6);
        bus_wr(2'd3, 32'h4);
        chk("set_wins_irq", {31'b0, irq}, 32'h1);
        bus_rd(2'd3, rd); chk("set_wins_ecap", rd, 32'h4);
        bus_wr(2'd3, 32'h4);
        bus_rd(2'd3, rd); chk("later_clear_bit2", rd, 32'h0);
        bus_rd(2'd0, rd); chk("data_bits02_low", rd, 32'hA);

        // reset in the middle of debouncing bit 3
        in_port = 4'h2;
        wait_clks(3);
        reset_n = 1'b0;
        wait_clks(1);
        chk("midreset_readdata", readdata, 32'h0);
        chk("midreset_irq", {31'b0, irq}, 32'h0);
        address    = 2'd3;
        chipselect = 1'b1;
        reset_n    = 1'b1;
        wait_clks(7);
        chk("rearm_ecap_not_yet", readdata, 32'h0);
        wait_clks(1);
        chk("rearm_ecap_set", readdata, 32'hD);
        bus_rd(2'd0, rd); chk("rearm_data", rd, 32'h2);
        bus_rd(2'd2, rd); chk("rearm_mask_reset", rd, 32'h0);
        chk("rearm_irq_masked", {31'b0, irq}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
